tophat_forest_core: RTL and testbench
=====================================

// Module: tophat_forest_core
// PURPOSE
//  Ensemble successor to the single-tree core. Evaluates NUM_TREES binary decision trees of
//  configurable DEPTH over one registered feature vector, one node per cycle. Sums signed leaf
//  values into a saturating accumulator and reports one prediction per run, with an error code.
//  Sits between the model/feature load registers and the host-visible result registers.
// PARAMETERS
//  NUM_FEATURES 8   features per vector; FIDX_W = $clog2(NUM_FEATURES) (min 1)
//  FEAT_W       8   unsigned feature and threshold width
//  DEPTH        3   max internal levels; NUM_INTERNAL = 2**DEPTH-1, NUM_LEAVES = 2**DEPTH
//  NUM_TREES    4   trees per ensemble; TIDX_W = $clog2(NUM_TREES) (min 1)
//  LEAF_W       8   signed leaf value width
//  ACC_W        12  signed accumulator/prediction width (>= LEAF_W)
//  Derived: CIDX_W = DEPTH+1 child index width; LEAF_BASE = NUM_INTERNAL.
// PORTS
//  clk               in  1  clock
//  rst_n             in  1  async active-low reset
//  clear_i           in  1  sync clear, same effect as reset
//  run_i             in  1  start request, sampled only in IDLE
//  model_loaded_i    in  1  model arrays valid
//  features_loaded_i in  1  feature vector valid
//  feature_vector_i  in  NUM_FEATURES*FEAT_W  feature f at [f*FEAT_W +: FEAT_W]
//  node_feature_i    in  NUM_TREES*NUM_INTERNAL*FIDX_W   entry k = t*NUM_INTERNAL+n
//  node_threshold_i  in  NUM_TREES*NUM_INTERNAL*FEAT_W   same indexing
//  node_left_i       in  NUM_TREES*NUM_INTERNAL*CIDX_W   child taken if feature <= threshold
//  node_right_i      in  NUM_TREES*NUM_INTERNAL*CIDX_W   child taken otherwise
//  leaf_value_i      in  NUM_TREES*NUM_LEAVES*LEAF_W     entry t*NUM_LEAVES+(child-LEAF_BASE)
//  busy_o            out 1  high while walking
//  tree_idx_o        out TIDX_W  tree currently being walked
//  pred_valid_o      out 1  one-cycle completion pulse
//  pred_value_o      out ACC_W  signed ensemble sum, held until next completion
//  sat_o             out 1  accumulator clipped during the last run
//  error_o           out 1  last run failed, held until next accepted run or clear
//  err_code_o        out 3  0 none, 1 NOT_LOADED, 2 BAD_CHILD, 3 DEPTH_EXCEEDED, 4 BAD_FEATURE
// BEHAVIOUR
//  Reset/clear: state=IDLE, all outputs 0, acc=0, step=0. Reset is async; clear_i is sync.
//  Priority: reset > clear > everything else. Reset or clear mid-walk aborts with no pulse.
//  IDLE: on run_i with both loaded flags set -> WALK. Set tree=0, node=0, step=0, acc=0.
//    Clear sat/error/err_code and raise busy_o. On run_i without them: error_o=1, code 1,
//    no pred_valid_o, stay IDLE. run_i is ignored outside IDLE.
//  WALK, one node per cycle:
//    feature idx >= NUM_FEATURES -> abort, code 4.
//    child >= NUM_INTERNAL+NUM_LEAVES -> abort, code 2.
//    child is internal and step == DEPTH-1 -> abort, code 3.
//    child is internal otherwise -> node = child, step + 1.
//    child is a leaf -> acc = sat(acc + sext(leaf)). If more trees remain: tree+1, node=0,
//    step=0. On the last tree: pred_value_o = new acc, pulse pred_valid_o, busy_o=0, -> IDLE.
//  Abort: pred_valid_o pulses with error_o=1, pred_value_o=0, busy_o=0, -> IDLE.
//  Saturation: clip to [-2**(ACC_W-1), 2**(ACC_W-1)-1] and set sat_o. Later adds continue
//    from the clipped value.
//  Compare is unsigned. Early leaves (step < DEPTH-1) are legal and shorten latency.
//  Latency: sum of the path lengths, in cycles, from the run_i sampling edge to pred_valid_o.
//    Full-depth trees give NUM_TREES*DEPTH cycles. pred_valid_o is never high with busy_o high.
//  Inputs must stay stable while busy_o is high; they are not registered.
// TESTING (DEPTH=3, NUM_TREES=4 unless stated)
//  1. Full-depth paths, every reached leaf = 8'sh10 -> pred 64 exactly 12 cycles after run,
//     sat_o=0, err_code 0.
//  2. Leaves -128 x4 -> pred -512. With ACC_W=8 override and leaves +100 x4 -> pred 127, sat_o=1.
//  3. Tree0 root left child = 7, feature below threshold -> tree0 takes 1 cycle, total 10 cycles.
//     The correct leaf 0 value is summed.
//  4. Root child = 15 -> pulse with error_o=1, code 2, pred 0. A clean rerun clears error_o.
//  5. run_i with features_loaded_i=0 -> error_o=1, code 1, busy_o stays 0, no pulse.
//     With a leaf at step 2 pointing to internal node 3 -> code 3.
//  6. Assert rst_n low mid-walk (async, between edges) -> outputs 0 immediately.
//     Repeat with clear_i -> outputs 0 after the next edge. In both cases no pred_valid_o pulse.

Source files
------------

// File: rtl/tophat_forest_core.sv
// Ensemble decision-tree evaluator: walks NUM_TREES binary trees one node per cycle over a
// shared feature vector and sums the reached leaf values into a saturating signed accumulator.
module tophat_forest_core #(
  parameter  int NUM_FEATURES = 8,
  parameter  int FEAT_W       = 8,
  parameter  int DEPTH        = 3,
  parameter  int NUM_TREES    = 4,
  parameter  int LEAF_W       = 8,
  parameter  int ACC_W        = 12,
  localparam int FIDX_W       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int TIDX_W       = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1,
  localparam int NUM_INTERNAL = (2 ** DEPTH) - 1,
  localparam int NUM_LEAVES   = 2 ** DEPTH,
  localparam int CIDX_W       = DEPTH + 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear_i,
  input  logic                                     run_i,
  input  logic                                     model_loaded_i,
  input  logic                                     features_loaded_i,
  input  logic [NUM_FEATURES*FEAT_W-1:0]           feature_vector_i,
  input  logic [NUM_TREES*NUM_INTERNAL*FIDX_W-1:0] node_feature_i,
  input  logic [NUM_TREES*NUM_INTERNAL*FEAT_W-1:0] node_threshold_i,
  input  logic [NUM_TREES*NUM_INTERNAL*CIDX_W-1:0] node_left_i,
  input  logic [NUM_TREES*NUM_INTERNAL*CIDX_W-1:0] node_right_i,
  input  logic [NUM_TREES*NUM_LEAVES*LEAF_W-1:0]   leaf_value_i,
  output logic                                     busy_o,
  output logic [TIDX_W-1:0]                        tree_idx_o,
  output logic                                     pred_valid_o,
  output logic [ACC_W-1:0]                         pred_value_o,
  output logic                                     sat_o,
  output logic                                     error_o,
  output logic [2:0]                               err_code_o
);

  localparam int LEAF_BASE    = NUM_INTERNAL;
  localparam int NUM_CHILDREN = NUM_INTERNAL + NUM_LEAVES;
  localparam int STEP_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NIDX_W       = DEPTH;

  localparam logic [2:0] ERR_NONE           = 3'd0;
  localparam logic [2:0] ERR_NOT_LOADED     = 3'd1;
  localparam logic [2:0] ERR_BAD_CHILD      = 3'd2;
  localparam logic [2:0] ERR_DEPTH_EXCEEDED = 3'd3;
  localparam logic [2:0] ERR_BAD_FEATURE    = 3'd4;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t              r_state;
  logic [TIDX_W-1:0]   r_tree;
  logic [NIDX_W-1:0]   r_node;
  logic [STEP_W-1:0]   r_step;
  logic [ACC_W-1:0]    r_acc;
  logic                r_busy;
  logic                r_valid;
  logic [ACC_W-1:0]    r_pred;
  logic                r_sat;
  logic                r_error;
  logic [2:0]          r_code;

  logic [FEAT_W-1:0]   w_feat   [NUM_FEATURES];
  logic [FIDX_W-1:0]   w_nfeat  [NUM_TREES][NUM_INTERNAL];
  logic [FEAT_W-1:0]   w_nthr   [NUM_TREES][NUM_INTERNAL];
  logic [CIDX_W-1:0]   w_nleft  [NUM_TREES][NUM_INTERNAL];
  logic [CIDX_W-1:0]   w_nright [NUM_TREES][NUM_INTERNAL];
  logic [LEAF_W-1:0]   w_leaves [NUM_TREES][NUM_LEAVES];

  logic [FIDX_W-1:0]   w_fidx;
  logic                w_fidx_bad;
  logic [FEAT_W-1:0]   w_fval;
  logic [FEAT_W-1:0]   w_thr;
  logic [CIDX_W-1:0]   w_child;
  logic                w_child_bad;
  logic                w_child_int;
  logic                w_last_step;
  logic                w_last_tree;
  logic [DEPTH-1:0]    w_leaf_off;
  logic [LEAF_W-1:0]   w_leaf;
  logic [ACC_W:0]      w_sum;
  logic                w_ovf;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_abort;
  logic [2:0]          w_abort_code;

  // Unpack the flat load-register buses into per-tree, per-node views.
  for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_feat
    assign w_feat[gi] = feature_vector_i[gi*FEAT_W +: FEAT_W];
  end

  for (genvar gi = 0; gi < NUM_TREES; gi++) begin : g_tree
    for (genvar gj = 0; gj < NUM_INTERNAL; gj++) begin : g_node
      localparam int K = gi*NUM_INTERNAL + gj;
      assign w_nfeat[gi][gj]  = node_feature_i[K*FIDX_W +: FIDX_W];
      assign w_nthr[gi][gj]   = node_threshold_i[K*FEAT_W +: FEAT_W];
      assign w_nleft[gi][gj]  = node_left_i[K*CIDX_W +: CIDX_W];
      assign w_nright[gi][gj] = node_right_i[K*CIDX_W +: CIDX_W];
    end
    for (genvar gj = 0; gj < NUM_LEAVES; gj++) begin : g_leaf
      localparam int L = gi*NUM_LEAVES + gj;
      assign w_leaves[gi][gj] = leaf_value_i[L*LEAF_W +: LEAF_W];
    end
  end

  assign w_fidx = w_nfeat[r_tree][r_node];
  assign w_thr  = w_nthr[r_tree][r_node];

  // A power-of-two feature count makes every encodable index legal.
  if (NUM_FEATURES == (2 ** FIDX_W)) begin : g_fidx_full
    assign w_fidx_bad = 1'b0;
  end else begin : g_fidx_part
    assign w_fidx_bad = (32'(w_fidx) >= NUM_FEATURES);
  end

  assign w_fval      = w_fidx_bad ? '0 : w_feat[w_fidx];
  assign w_child     = (w_fval <= w_thr) ? w_nleft[r_tree][r_node] : w_nright[r_tree][r_node];
  assign w_child_bad = (w_child >= CIDX_W'(NUM_CHILDREN));
  assign w_child_int = (w_child < CIDX_W'(NUM_INTERNAL));
  assign w_last_step = (r_step == STEP_W'(DEPTH - 1));
  assign w_last_tree = (r_tree == TIDX_W'(NUM_TREES - 1));

  assign w_leaf_off = w_child[DEPTH-1:0] - DEPTH'(LEAF_BASE);
  assign w_leaf     = w_leaves[r_tree][w_leaf_off];

  // One guard bit catches overflow; clip toward the sign of the true sum.
  assign w_sum      = {r_acc[ACC_W-1], r_acc}
                    + {{(ACC_W+1-LEAF_W){w_leaf[LEAF_W-1]}}, w_leaf};
  assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_next = w_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

  always_comb begin
    w_abort      = 1'b0;
    w_abort_code = ERR_NONE;
    if (w_fidx_bad) begin
      w_abort      = 1'b1;
      w_abort_code = ERR_BAD_FEATURE;
    end else if (w_child_bad) begin
      w_abort      = 1'b1;
      w_abort_code = ERR_BAD_CHILD;
    end else if (w_child_int && w_last_step) begin
      w_abort      = 1'b1;
      w_abort_code = ERR_DEPTH_EXCEEDED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tree  <= '0;
      r_node  <= '0;
      r_step  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_pred  <= '0;
      r_sat   <= 1'b0;
      r_error <= 1'b0;
      r_code  <= ERR_NONE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
      r_tree  <= '0;
      r_node  <= '0;
      r_step  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_pred  <= '0;
      r_sat   <= 1'b0;
      r_error <= 1'b0;
      r_code  <= ERR_NONE;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run_i) begin
            if (model_loaded_i && features_loaded_i) begin
              r_state <= S_WALK;
              r_tree  <= '0;
              r_node  <= '0;
              r_step  <= '0;
              r_acc   <= '0;
              r_sat   <= 1'b0;
              r_error <= 1'b0;
              r_code  <= ERR_NONE;
              r_busy  <= 1'b1;
            end else begin
              r_error <= 1'b1;
              r_code  <= ERR_NOT_LOADED;
            end
          end
        end
        S_WALK: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_pred  <= '0;
            r_error <= 1'b1;
            r_code  <= w_abort_code;
          end else if (w_child_int) begin
            r_node <= w_child[NIDX_W-1:0];
            r_step <= r_step + STEP_W'(1);
          end else begin
            r_acc <= w_acc_next;
            if (w_ovf) begin
              r_sat <= 1'b1;
            end
            if (w_last_tree) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
              r_pred  <= w_acc_next;
            end else begin
              r_tree <= r_tree + TIDX_W'(1);
              r_node <= '0;
              r_step <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign tree_idx_o   = r_tree;
  assign pred_valid_o = r_valid;
  assign pred_value_o = r_pred;
  assign sat_o        = r_sat;
  assign error_o      = r_error;
  assign err_code_o   = r_code;

endmodule

// File: tb/tb_tophat_forest_core.sv
// Directed and randomized checks of tophat_forest_core against an array-based tree-walk model,
// with a second instance at ACC_W=8 to exercise saturation on the same stimulus.
module tb_tophat_forest_core;
  localparam int NF  = 8;
  localparam int FW  = 8;
  localparam int D   = 3;
  localparam int NT  = 4;
  localparam int LW  = 8;
  localparam int NI  = 7;
  localparam int NL  = 8;
  localparam int CW  = 4;
  localparam int FIW = 3;
  localparam int TIW = 2;

  logic clk, rst_n, clear_i, run_i, model_loaded_i, features_loaded_i;
  logic [NF*FW-1:0]     feature_vector;
  logic [NT*NI*FIW-1:0] node_feature;
  logic [NT*NI*FW-1:0]  node_threshold;
  logic [NT*NI*CW-1:0]  node_left;
  logic [NT*NI*CW-1:0]  node_right;
  logic [NT*NL*LW-1:0]  leaf_value;

  logic           busy_o, pred_valid_o, sat_o, error_o;
  logic [TIW-1:0] tree_idx_o;
  logic [11:0]    pred_value_o;
  logic [2:0]     err_code_o;
  logic           busy_8, pred_valid_8, sat_8, error_8;
  logic [TIW-1:0] tree_idx_8;
  logic [7:0]     pred_value_8;
  logic [2:0]     err_code_8;

  int checks = 0;
  int errors = 0;

  int m_fidx [NT][NI];
  int m_thr  [NT][NI];
  int m_left [NT][NI];
  int m_right[NT][NI];
  int m_leaf [NT][NL];
  int m_feat [NF];

  tophat_forest_core #(.ACC_W(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .run_i(run_i),
    .model_loaded_i(model_loaded_i), .features_loaded_i(features_loaded_i),
    .feature_vector_i(feature_vector), .node_feature_i(node_feature),
    .node_threshold_i(node_threshold), .node_left_i(node_left), .node_right_i(node_right),
    .leaf_value_i(leaf_value), .busy_o(busy_o), .tree_idx_o(tree_idx_o),
    .pred_valid_o(pred_valid_o), .pred_value_o(pred_value_o), .sat_o(sat_o),
    .error_o(error_o), .err_code_o(err_code_o)
  );

  tophat_forest_core #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .run_i(run_i),
    .model_loaded_i(model_loaded_i), .features_loaded_i(features_loaded_i),
    .feature_vector_i(feature_vector), .node_feature_i(node_feature),
    .node_threshold_i(node_threshold), .node_left_i(node_left), .node_right_i(node_right),
    .leaf_value_i(leaf_value), .busy_o(busy_8), .tree_idx_o(tree_idx_8),
    .pred_valid_o(pred_valid_8), .pred_value_o(pred_value_8), .sat_o(sat_8),
    .error_o(error_8), .err_code_o(err_code_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int f = 0; f < NF; f++) feature_vector[f*FW +: FW] = FW'(m_feat[f]);
    for (int t = 0; t < NT; t++) begin
      for (int n = 0; n < NI; n++) begin
        node_feature[(t*NI+n)*FIW +: FIW] = FIW'(m_fidx[t][n]);
        node_threshold[(t*NI+n)*FW +: FW] = FW'(m_thr[t][n]);
        node_left[(t*NI+n)*CW +: CW]      = CW'(m_left[t][n]);
        node_right[(t*NI+n)*CW +: CW]     = CW'(m_right[t][n]);
      end
      for (int l = 0; l < NL; l++) leaf_value[(t*NL+l)*LW +: LW] = LW'(m_leaf[t][l]);
    end
  endtask

  // Complete binary trees (children 2n+1 / 2n+2), random splits, all leaves equal.
  task automatic setup_full(input int leafval);
    for (int f = 0; f < NF; f++) m_feat[f] = int'($urandom_range(0, 255));
    for (int t = 0; t < NT; t++) begin
      for (int n = 0; n < NI; n++) begin
        m_fidx[t][n]  = int'($urandom_range(0, NF-1));
        m_thr[t][n]   = int'($urandom_range(0, 255));
        m_left[t][n]  = 2*n + 1;
        m_right[t][n] = 2*n + 2;
      end
      for (int l = 0; l < NL; l++) m_leaf[t][l] = leafval;
    end
    pack();
  endtask

  function automatic int pick_child(input int n, input int side);
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 0) return 15;
    if (r == 1) return int'($urandom_range(0, NI-1));
    if (r <= 5) return int'($urandom_range(NI, NI+NL-1));
    return 2*n + 1 + side;
  endfunction

  task automatic setup_random();
    for (int f = 0; f < NF; f++) m_feat[f] = int'($urandom_range(0, 255));
    for (int t = 0; t < NT; t++) begin
      for (int n = 0; n < NI; n++) begin
        m_fidx[t][n]  = int'($urandom_range(0, NF-1));
        m_thr[t][n]   = int'($urandom_range(0, 255));
        m_left[t][n]  = pick_child(n, 0);
        m_right[t][n] = pick_child(n, 1);
      end
      for (int l = 0; l < NL; l++) m_leaf[t][l] = int'($urandom_range(0, 255)) - 128;
    end
    pack();
  endtask

  // Walk each tree from its root; count one cycle per visited node.
  task automatic model(input int acc_w, output int pred, output int err,
                       output int sat, output int lat);
    int acc, lo, hi, node, lvl, child;
    bit done;
    acc = 0; sat = 0; lat = 0; err = 0;
    lo = -(1 << (acc_w-1));
    hi = (1 << (acc_w-1)) - 1;
    for (int t = 0; t < NT && err == 0; t++) begin
      node = 0; lvl = 0; done = 0;
      while (!done) begin
        lat++;
        if (m_fidx[t][node] >= NF) begin
          err = 4; done = 1;
        end else begin
          child = (m_feat[m_fidx[t][node]] <= m_thr[t][node]) ? m_left[t][node] : m_right[t][node];
          if (child >= NI + NL) begin
            err = 2; done = 1;
          end else if (child < NI) begin
            if (lvl == D-1) begin
              err = 3; done = 1;
            end else begin
              node = child; lvl++;
            end
          end else begin
            acc = acc + m_leaf[t][child-NI];
            if (acc > hi) begin acc = hi; sat = 1; end
            if (acc < lo) begin acc = lo; sat = 1; end
            done = 1;
          end
        end
      end
    end
    pred = (err != 0) ? 0 : acc;
  endtask

  task automatic start_run();
    @(negedge clk);
    run_i = 1'b1;
    @(posedge clk);
    #1 run_i = 1'b0;
  endtask

  task automatic run_check(input string tag, input int e_pred, input int e_err, input int e_sat,
                           input int e_lat, input int e_pred8, input int e_sat8, input bit do_sat);
    int cyc;
    bit got;
    start_run();
    chk({tag, "_busy_start"}, busy_o, 1);
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      if (pred_valid_o) got = 1;
    end
    chk({tag, "_pulse_seen"}, got, 1);
    if (got) begin
      chk({tag, "_latency"}, cyc, e_lat);
      chk({tag, "_pred"}, $signed(pred_value_o), e_pred);
      chk({tag, "_error"}, error_o, (e_err != 0) ? 1 : 0);
      chk({tag, "_code"}, err_code_o, e_err);
      chk({tag, "_busy_end"}, busy_o, 0);
      chk({tag, "_pulse8"}, pred_valid_8, 1);
      chk({tag, "_pred8"}, $signed(pred_value_8), e_pred8);
      chk({tag, "_code8"}, err_code_8, e_err);
      if (do_sat) begin
        chk({tag, "_sat"}, sat_o, e_sat);
        chk({tag, "_sat8"}, sat_8, e_sat8);
      end
      @(posedge clk);
      #1 chk({tag, "_pulse_width"}, pred_valid_o, 0);
    end
    $display("run %s: latency=%0d pred=%0d pred8=%0d code=%0d sat=%0d sat8=%0d", tag, cyc,
             $signed(pred_value_o), $signed(pred_value_8), err_code_o, sat_o, sat_8);
  endtask

  task automatic no_pulse(input string tag, input int ncyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1 if (pred_valid_o || pred_valid_8) seen = 1;
    end
    chk({tag, "_no_pulse"}, seen, 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_tree"}, tree_idx_o, 0);
    chk({tag, "_valid"}, pred_valid_o, 0);
    chk({tag, "_pred"}, pred_value_o, 0);
    chk({tag, "_sat"}, sat_o, 0);
    chk({tag, "_error"}, error_o, 0);
    chk({tag, "_code"}, err_code_o, 0);
    chk({tag, "_busy8"}, busy_8, 0);
  endtask

  initial begin
    int p12, e12, s12, l12, p8, e8, s8, l8;
    rst_n = 1'b0; clear_i = 1'b0; run_i = 1'b0;
    model_loaded_i = 1'b1; features_loaded_i = 1'b1;
    setup_full(16);
    #12;
    all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    setup_full(16);
    run_check("full_depth_16", 64, 0, 0, 12, 64, 0, 1);

    setup_full(-128);
    run_check("neg_128", -512, 0, 0, 12, -128, 1, 1);

    setup_full(100);
    run_check("pos_100_sat", 400, 0, 0, 12, 127, 1, 1);

    setup_full(16);
    m_fidx[0][0] = 0; m_feat[0] = 10; m_thr[0][0] = 50;
    m_left[0][0] = 7; m_leaf[0][0] = 5; m_leaf[0][1] = 99;
    pack();
    run_check("early_leaf", 53, 0, 0, 10, 53, 0, 1);

    setup_full(16);
    m_left[0][0] = 15; m_right[0][0] = 15;
    pack();
    run_check("bad_child", 0, 2, 0, 1, 0, 0, 0);

    setup_full(16);
    run_check("clean_rerun", 64, 0, 0, 12, 64, 0, 1);

    features_loaded_i = 1'b0;
    start_run();
    chk("not_loaded_error", error_o, 1);
    chk("not_loaded_code", err_code_o, 1);
    chk("not_loaded_busy", busy_o, 0);
    no_pulse("not_loaded", 14);
    features_loaded_i = 1'b1;

    setup_full(16);
    m_left[0][0] = 1; m_right[0][0] = 1;
    m_left[0][1] = 3; m_right[0][1] = 3;
    m_left[0][3] = 3; m_right[0][3] = 3;
    pack();
    run_check("depth_exceeded", 0, 3, 0, 3, 0, 0, 0);

    setup_full(16);
    run_check("pre_reset_run", 64, 0, 0, 12, 64, 0, 1);
    start_run();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    no_pulse("async_reset", 16);

    run_check("pre_clear_run", 64, 0, 0, 12, 64, 0, 1);
    start_run();
    repeat (4) @(posedge clk);
    @(negedge clk) clear_i = 1'b1;
    chk("clear_before_edge_busy", busy_o, 1);
    @(posedge clk);
    #1 all_zero("sync_clear");
    clear_i = 1'b0;
    no_pulse("sync_clear", 16);

    for (int i = 0; i < 40; i++) begin
      setup_random();
      model(12, p12, e12, s12, l12);
      model(8, p8, e8, s8, l8);
      run_check($sformatf("rand%0d", i), p12, e12, s12, l12, p8, s8, e12 == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
